// File: rtl/sound_arbiter.sv
// sound_arbiter: selects one of NUM_CH sound sources for the tone/audio stage.
// Channel 0 is the background source; higher-index event channels pre-empt
// lower ones, hold the output for HOLD_CYCLES, and queue lower-priority events.
module sound_arbiter #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned TONE_W      = 4,
  parameter int unsigned HOLD_CYCLES = 12_500_000,
  parameter logic [1:0]  WIN_CODE    = 2'b10,
  parameter int unsigned WIN_CH      = NUM_CH - 1
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       enableSound,
  input  logic [1:0]                 levelCode,
  input  logic [NUM_CH-1:0]          req,
  input  logic [NUM_CH-1:0]          enable_in,
  input  logic [NUM_CH*TONE_W-1:0]   tone_in,
  output logic                       enable_out,
  output logic [TONE_W-1:0]          tone,
  output logic [$clog2(NUM_CH)-1:0]  active_ch,
  output logic                       busy
);

  localparam int unsigned CH_W  = $clog2(NUM_CH);
  localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0]  RELOAD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CH_W-1:0]   WIN_IDX = CH_W'(WIN_CH);
  localparam logic [NUM_CH-1:0] EV_MASK = ~(NUM_CH'(1));

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_FORCED, S_MUTE} state_t;

  state_t              state, state_nx;
  logic [CH_W-1:0]     cur, cur_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic [NUM_CH-1:0]   pend, pend_nx;   // bit 0 is never set
  logic                en_nx, busy_nx;
  logic [TONE_W-1:0]   tone_nx;

  logic [NUM_CH-1:0]   req_ev, hi_oh, cur_oh, merged, mhi_oh;
  logic [CH_W-1:0]     hi, mhi;

  // Highest set index among bits 1..NUM_CH-1 (0 when none set)
  function automatic logic [CH_W-1:0] highest(input logic [NUM_CH-1:0] v);
    logic [CH_W-1:0] r;
    r = '0;
    for (int i = 1; i < NUM_CH; i++) begin
      if (v[i]) r = CH_W'(i);
    end
    return r;
  endfunction

  // State register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= S_IDLE;
    else         state <= state_nx;
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cur        <= '0;
      cnt        <= '0;
      pend       <= '0;
      enable_out <= 1'b0;
      tone       <= '0;
      busy       <= 1'b0;
    end else begin
      cur        <= cur_nx;
      cnt        <= cnt_nx;
      pend       <= pend_nx;
      enable_out <= en_nx;
      tone       <= tone_nx;
      busy       <= busy_nx;
    end
  end

  assign active_ch = cur;

  // Next-state arbitration and next output selection
  always_comb begin
    state_nx = state;
    cur_nx   = cur;
    cnt_nx   = cnt;
    pend_nx  = pend;
    en_nx    = 1'b0;
    tone_nx  = '0;
    busy_nx  = 1'b0;
    req_ev   = req & EV_MASK;
    hi       = highest(req_ev);
    hi_oh    = NUM_CH'(1) << hi;
    cur_oh   = NUM_CH'(1) << cur;
    merged   = (pend | req_ev) & EV_MASK;
    mhi      = highest(merged);
    mhi_oh   = NUM_CH'(1) << mhi;

    if (!enableSound) begin
      state_nx = S_MUTE;
      cur_nx   = '0;
      cnt_nx   = '0;
      pend_nx  = '0;
    end else begin
      case (state)
        S_MUTE: begin
          state_nx = S_IDLE;
          cur_nx   = '0;
          cnt_nx   = '0;
          pend_nx  = '0;
        end
        S_FORCED: begin
          cnt_nx  = '0;
          pend_nx = '0;
          if (levelCode != WIN_CODE) begin
            state_nx = S_IDLE;
            cur_nx   = '0;
          end else begin
            cur_nx = WIN_IDX;
          end
        end
        S_IDLE, S_PLAY: begin
          if (levelCode == WIN_CODE) begin
            state_nx = S_FORCED;
            cur_nx   = WIN_IDX;
            cnt_nx   = '0;
            pend_nx  = '0;
          end else if (state == S_IDLE) begin
            if (req_ev != '0) begin
              state_nx = S_PLAY;
              cur_nx   = hi;
              cnt_nx   = RELOAD;
              pend_nx  = merged & ~hi_oh;
            end
          end else if ((req_ev != '0) && (hi > cur)) begin
            // Pre-empt: the interrupted channel is dropped, not queued
            cur_nx  = hi;
            cnt_nx  = RELOAD;
            pend_nx = merged & ~hi_oh & ~cur_oh;
          end else if ((req_ev != '0) && (hi == cur)) begin
            cnt_nx  = RELOAD;
            pend_nx = merged & ~hi_oh;
          end else if (cnt == '0) begin
            // Expiry: start the best queued event back-to-back, else go idle
            if (merged != '0) begin
              cur_nx  = mhi;
              cnt_nx  = RELOAD;
              pend_nx = merged & ~mhi_oh;
            end else begin
              state_nx = S_IDLE;
              cur_nx   = '0;
              pend_nx  = '0;
            end
          end else begin
            cnt_nx  = cnt - CNT_W'(1);
            pend_nx = merged;
          end
        end
        default: begin
          state_nx = S_IDLE;
          cur_nx   = '0;
          cnt_nx   = '0;
          pend_nx  = '0;
        end
      endcase
    end

    if (state_nx != S_MUTE) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cur_nx == CH_W'(i)) begin
          en_nx   = enable_in[i];
          tone_nx = tone_in[i*TONE_W +: TONE_W];
        end
      end
    end
    busy_nx = (state_nx == S_PLAY) || (state_nx == S_FORCED);
  end

endmodule

// File: tb/tb_sound_arbiter.sv
// tb_sound_arbiter: directed vector table plus reset sequences for sound_arbiter.
module tb_sound_arbiter;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned TONE_W = 4;
  localparam int unsigned HOLD   = 4;

  logic                     clk;
  logic                     resetN;
  logic                     enableSound;
  logic [1:0]               levelCode;
  logic [NUM_CH-1:0]        req;
  logic [NUM_CH-1:0]        enable_in;
  logic [NUM_CH*TONE_W-1:0] tone_in;
  logic                     enable_out;
  logic [TONE_W-1:0]        tone;
  logic [1:0]               active_ch;
  logic                     busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] req;
    logic       en_snd;
    logic [1:0] lvl;
    logic [3:0] en_in;
    logic [3:0] e_tone;
    logic       e_en;
    logic [1:0] e_ch;
    logic       e_busy;
  } vec_t;

  vec_t vecs[$];

  sound_arbiter #(
    .NUM_CH(NUM_CH),
    .TONE_W(TONE_W),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .enableSound(enableSound),
    .levelCode(levelCode),
    .req(req),
    .enable_in(enable_in),
    .tone_in(tone_in),
    .enable_out(enable_out),
    .tone(tone),
    .active_ch(active_ch),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_tone, input logic e_en,
                         input logic [1:0] e_ch, input logic e_busy);
    chk({tag, " tone"}, int'(tone), int'(e_tone));
    chk({tag, " enable_out"}, int'(enable_out), int'(e_en));
    chk({tag, " active_ch"}, int'(active_ch), int'(e_ch));
    chk({tag, " busy"}, int'(busy), int'(e_busy));
  endtask

  task automatic add(input logic [3:0] r, input logic es, input logic [1:0] lv,
                     input logic [3:0] ei, input logic [3:0] et, input logic ee,
                     input logic [1:0] ec, input logic eb);
    vec_t v;
    v.req = r; v.en_snd = es; v.lvl = lv; v.en_in = ei;
    v.e_tone = et; v.e_en = ee; v.e_ch = ec; v.e_busy = eb;
    vecs.push_back(v);
  endtask

  initial begin
    // Tones: ch0=1, ch1=5, ch2=A, ch3=C
    tone_in     = 16'hCA51;
    enable_in   = 4'b1111;
    enableSound = 1'b1;
    levelCode   = 2'b00;
    req         = 4'b0000;
    resetN      = 1'b1;

    // Idle background
    add(4'b0000, 1, 2'b00, 4'hF, 4'h1, 1, 2'd0, 0);
    // Single event ch1: 4 cycles then back to ch0
    add(4'b0010, 1, 2'b00, 4'hF, 4'h5, 1, 2'd1, 1);
    add(4'b0000, 1, 2'b00, 4'hF, 4'h5, 1, 2'd1, 1);
    add(4'b0000, 1, 2'b00, 4'hF, 4'h5, 1, 2'd1, 1);
    add(4'b0000, 1, 2'b00, 4'hF, 4'h5, 1, 2'd1, 1);
    add(4'b0000, 1, 2'b00, 4'hF, 4'h1, 1, 2'd0, 0);
    // Simultaneous ch2+ch1: ch2 x4, ch1 x4 back-to-back, then ch0
    add(4'b0110, 1, 2'b00, 4'hF, 4'hA, 1, 2'd2, 1);
    add(4'b0000, 1, 2'b00, 4'hF, 4'hA, 1, 2'd2, 1);
    add(4'b0000, 1, 2'b00, 4'hF, 4'hA, 1, 2'd2, 1);
    add(4'b0000, 1, 2'b00, 4'hF, 4'hA, 1, 2'd2, 1);
    add(4'b0000, 1, 2'b00, 4'hF, 4'h5, 1, 2'd1, 1);
    add(4'b0000, 1, 2'b00, 4'hF, 4'h5, 1, 2'd1, 1);
    add(4'b0000, 1, 2'b00, 4'hF, 4'h5, 1, 2'd1, 1);
    add(4'b0000, 1, 2'b00, 4'hF, 4'h5, 1, 2'd1, 1);
    add(4'b0000, 1, 2'b00, 4'hF, 4'h1, 1, 2'd0, 0);
    // Pre-empt ch1 by ch3, restart ch3 in its 3rd cycle: ch3 for 7 cycles
    add(4'b0010, 1, 2'b00, 4'hF, 4'h5, 1, 2'd1, 1);
    add(4'b1000, 1, 2'b00, 4'hF, 4'hC, 1, 2'd3, 1);
    add(4'b0000, 1, 2'b00, 4'hF, 4'hC, 1, 2'd3, 1);
    add(4'b0000, 1, 2'b00, 4'hF, 4'hC, 1, 2'd3, 1);
    add(4'b1000, 1, 2'b00, 4'hF, 4'hC, 1, 2'd3, 1);
    add(4'b0000, 1, 2'b00, 4'hF, 4'hC, 1, 2'd3, 1);
    add(4'b0000, 1, 2'b00, 4'hF, 4'hC, 1, 2'd3, 1);
    add(4'b0000, 1, 2'b00, 4'hF, 4'hC, 1, 2'd3, 1);
    add(4'b0000, 1, 2'b00, 4'hF, 4'h1, 1, 2'd0, 0);
    // enable_out follows the selected channel's live enable
    add(4'b0000, 1, 2'b00, 4'hE, 4'h1, 0, 2'd0, 0);
    add(4'b0000, 1, 2'b00, 4'hF, 4'h1, 1, 2'd0, 0);
    // Override during PLAY ch2 with ch1 queued; queued ch1 is discarded
    add(4'b0110, 1, 2'b00, 4'hF, 4'hA, 1, 2'd2, 1);
    add(4'b0000, 1, 2'b10, 4'hF, 4'hC, 1, 2'd3, 1);
    add(4'b0000, 1, 2'b10, 4'hF, 4'hC, 1, 2'd3, 1);
    add(4'b0010, 1, 2'b10, 4'hF, 4'hC, 1, 2'd3, 1);
    add(4'b0000, 1, 2'b00, 4'hF, 4'h1, 1, 2'd0, 0);
    add(4'b0000, 1, 2'b00, 4'hF, 4'h1, 1, 2'd0, 0);
    add(4'b0000, 1, 2'b00, 4'hF, 4'h1, 1, 2'd0, 0);
    add(4'b0000, 1, 2'b00, 4'hF, 4'h1, 1, 2'd0, 0);
    add(4'b0000, 1, 2'b00, 4'hF, 4'h1, 1, 2'd0, 0);
    add(4'b0000, 1, 2'b00, 4'hF, 4'h1, 1, 2'd0, 0);
    // Mute beats override and requests; unmute goes via IDLE to FORCED
    add(4'b1000, 0, 2'b10, 4'hF, 4'h0, 0, 2'd0, 0);
    add(4'b0000, 0, 2'b10, 4'hF, 4'h0, 0, 2'd0, 0);
    add(4'b0000, 1, 2'b10, 4'hF, 4'h1, 1, 2'd0, 0);
    add(4'b0000, 1, 2'b10, 4'hF, 4'hC, 1, 2'd3, 1);
    add(4'b0000, 0, 2'b10, 4'hF, 4'h0, 0, 2'd0, 0);
    add(4'b0000, 1, 2'b00, 4'hF, 4'h1, 1, 2'd0, 0);
    // Mute mid-PLAY discards the event
    add(4'b0010, 1, 2'b00, 4'hF, 4'h5, 1, 2'd1, 1);
    add(4'b0000, 0, 2'b00, 4'hF, 4'h0, 0, 2'd0, 0);
    add(4'b0000, 1, 2'b00, 4'hF, 4'h1, 1, 2'd0, 0);
    add(4'b0000, 1, 2'b00, 4'hF, 4'h1, 1, 2'd0, 0);

    // Async reset at time 2, held across an edge
    #2 resetN = 1'b0;
    #6 chk_all("reset", 4'h0, 1'b0, 2'd0, 1'b0);
    #4 resetN = 1'b1;

    foreach (vecs[k]) begin
      req         = vecs[k].req;
      enableSound = vecs[k].en_snd;
      levelCode   = vecs[k].lvl;
      enable_in   = vecs[k].en_in;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d", k), 0, 0 + int'(tone != vecs[k].e_tone));
      chk_all($sformatf("row%0d", k), vecs[k].e_tone, vecs[k].e_en,
              vecs[k].e_ch, vecs[k].e_busy);
    end

    // Reset asserted while ch2 plays: outputs clear immediately
    req = 4'b0100; enableSound = 1'b1; levelCode = 2'b00; enable_in = 4'hF;
    @(posedge clk); #1;
    chk_all("pre_reset", 4'hA, 1'b1, 2'd2, 1'b1);
    req = 4'b0000;
    @(posedge clk); #1;
    chk_all("pre_reset2", 4'hA, 1'b1, 2'd2, 1'b1);
    #1 resetN = 1'b0;
    #1 chk_all("mid_reset", 4'h0, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    resetN = 1'b1;
    @(posedge clk); #1;
    chk_all("post_reset", 4'h1, 1'b1, 2'd0, 1'b0);
    tone_in = 16'hCA57;
    @(posedge clk); #1;
    chk_all("post_reset_live", 4'h7, 1'b1, 2'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
